// File: rtl/collapse.sv
// collapse -- run-length encoder.
//
// Consumes a stream of words and emits one (value, count) pair per run of
// consecutive equal words. A run closes when a different word arrives, when
// its count reaches the maximum representable value, or on a flush request.
// Closed runs wait in a one-entry output slot until the downstream side acks.
// The output is registered, so there is no combinational path from the input
// to the output. The input ack depends only on the slot state and out_ack.
//
// Parameters:
//   DATA_WIDTH  width of the data words
//   COUNT_WIDTH width of the run count; the longest run is 2^COUNT_WIDTH-1
//   IDLE_LIMIT  idle cycles before an automatic close (1..255), used only
//               when COLLAPSE_AUTOFLUSH_EN is defined
//
// Optional feature macro: COLLAPSE_AUTOFLUSH_EN
//   When defined, an open run that sees no input for IDLE_LIMIT cycles is
//   closed as if flush were high.
//
// Ports:
//   clock      sole clock, rising edge
//   reset_n    asynchronous active-low reset
//   flush      level request to close the open run
//   in_valid   input word valid
//   in_ack     input word accepted this cycle
//   in_data    input word
//   out_valid  run pair available
//   out_ack    downstream accepts the pair
//   out_data   run value
//   out_count  run length belonging to out_data (never 0 while out_valid)

module collapse #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16,
    parameter int IDLE_LIMIT  = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ack,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ack,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [COUNT_WIDTH-1:0] out_count
);

    localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = '1;
    localparam logic [COUNT_WIDTH-1:0] ONE_COUNT = COUNT_WIDTH'(1);

    logic [DATA_WIDTH-1:0]  run_value;
    logic [COUNT_WIDTH-1:0] run_count;
    logic                   slot_valid;
    logic [DATA_WIDTH-1:0]  slot_data;
    logic [COUNT_WIDTH-1:0] slot_count;

    logic slot_free;
    logic consume;
    logic run_open;
    logic split;
    logic close;
    logic load;
    logic idle_flush;
    logic flush_req;

    // Any load of the slot (split or close) is only allowed while the slot is
    // free, so a full slot with no ack stalls all input, even a matching word.
    assign slot_free = !slot_valid || out_ack;
    assign in_ack    = slot_free;
    assign consume   = in_valid && slot_free;
    assign run_open  = (run_count != '0);

    // A saturated run splits even on a matching word, so it restarts with the
    // same value and count 1.
    assign split = consume && run_open &&
                   ((in_data != run_value) || (run_count == MAX_COUNT));

    // Input wins over flush: a consumed word joins or starts a run and any
    // close happens on a later cycle.
    assign flush_req = flush || idle_flush;
    assign close     = flush_req && run_open && slot_free && !consume;
    assign load      = split || close;

`ifdef COLLAPSE_AUTOFLUSH_EN
    localparam logic [7:0] IDLE_MAX = 8'(IDLE_LIMIT);

    logic [7:0] idle_count;

    assign idle_flush = (idle_count == IDLE_MAX);

    // Counts cycles an open run goes without input; saturates at the limit so
    // a run blocked by a full slot closes as soon as the slot frees up.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idle_count <= '0;
        end else if (consume || close) begin
            idle_count <= '0;
        end else if (run_open && (idle_count != IDLE_MAX)) begin
            idle_count <= idle_count + 8'd1;
        end
    end
`else
    // Without the idle counter there is no automatic close; IDLE_LIMIT is
    // never 0, so this term is constant low.
    assign idle_flush = (IDLE_LIMIT == 0);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run_value <= '0;
            run_count <= '0;
        end else if (consume) begin
            if (!run_open || split) begin
                run_value <= in_data;
                run_count <= ONE_COUNT;
            end else begin
                run_count <= run_count + ONE_COUNT;
            end
        end else if (close) begin
            run_count <= '0;
        end
    end

    // The slot always captures the run as it stood before this edge; a drain
    // with no simultaneous load empties it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_valid <= 1'b0;
            slot_data  <= '0;
            slot_count <= '0;
        end else if (load) begin
            slot_valid <= 1'b1;
            slot_data  <= run_value;
            slot_count <= run_count;
        end else if (slot_valid && out_ack) begin
            slot_valid <= 1'b0;
        end
    end

    assign out_valid = slot_valid;
    assign out_data  = slot_data;
    assign out_count = slot_count;

endmodule
